// File: rtl/div_sched_pkg.sv
// Shared types and default sizing for the divider scheduler.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping, wins.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDXW-1:0]  gnt_idx_o,
  output logic             valid_o
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        gnt_o[idx]   = 1'b1;
        gnt_idx_o    = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Shares one start/done sequential divider among N_REQ requesters with
// round-robin priority; divide-by-zero is answered locally.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_q,
  output logic [WIDTH-1:0]       rsp_r,
  output logic                   rsp_dz,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_a,
  output logic [WIDTH-1:0]       div_b,
  input  logic                   div_done,
  input  logic [WIDTH-1:0]       div_q,
  input  logic [WIDTH-1:0]       div_r
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  q_q, q_d, r_q, r_d;
  logic              dz_q, dz_d, err_q, err_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0]  gnt;
  logic [IDXW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic [WIDTH-1:0]  a_sel, b_sel;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .valid_o   (gnt_valid)
  );

  assign a_sel = req_a[gnt_idx*WIDTH +: WIDTH];
  assign b_sel = req_b[gnt_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    r_d      = r_q;
    dz_d     = dz_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          a_d     = a_sel;
          b_d     = b_sel;
          if (b_sel == '0) begin
            q_d     = '1;
            r_d     = a_sel;
            dz_d    = 1'b1;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the timeout cycle still wins over the abort.
        if (div_done) begin
          q_d     = div_q;
          r_d     = div_r;
          dz_d    = 1'b0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          q_d     = '0;
          r_d     = '0;
          dz_d    = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rsp_valid_d = '0;
    if (state_d == RESP) rsp_valid_d[owner_d] = 1'b1;
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDXW'(N_REQ - 1);
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dz_q        <= dz_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // ack is gated by rst so every output reads zero while reset is held.
  assign ack       = (state_q == IDLE && !rst) ? gnt : '0;
  assign div_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign rsp_q     = q_q;
  assign rsp_r     = r_q;
  assign rsp_dz    = dz_q;
  assign rsp_err   = err_q;
  assign rsp_valid = rsp_valid_q;

endmodule
